// File: rtl/ex_pkg.sv
// Shared types for the execute stage: decoded op enums, FSM states and the
// control half of the EX/MEM payload.
package ex_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL = 3'd0, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic [1:0] wb_ctl;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic [4:0] rd;
  } exmem_ctl_t;
endpackage

// File: rtl/ex_stage_md_muldiv.sv
// Iterative radix-2 multiply/divide: shift-add multiply, restoring divide on
// magnitudes with sign fixup. Divide special cases are preloaded at start.
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            kill,
  input  logic            start,
  input  logic            run,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            special,
  output logic            last,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d, ash_q, ash_d, addend;
  logic [XLEN-1:0]   b_q, b_d, a_mag, b_mag, quo, rem;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              bneg_q, bneg_d, negq_q, negq_d, negr_q, negr_d;
  logic              is_div, sgn_div, a_neg, b_neg, div0, ovf;
  logic [XLEN:0]     hi, diff;

  always_comb begin
    is_div  = op[2];
    sgn_div = is_div && !op[0];
    a_neg   = a[XLEN-1] && (is_div ? sgn_div : (op == MD_MULH || op == MD_MULHSU));
    b_neg   = sgn_div && b[XLEN-1];
    div0    = is_div && (b == '0);
    ovf     = sgn_div && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
    special = div0 || ovf;
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    last    = (cnt_q == '0);
    addend  = b_q[0] ? ash_q : '0;
    // Acc holds {remainder, dividend/quotient}; shift one bit up into hi.
    hi      = acc_q[2*XLEN-1:XLEN-1];
    diff    = hi - {1'b0, b_q};
    quo     = acc_q[XLEN-1:0];
    rem     = acc_q[2*XLEN-1:XLEN];

    op_d = op_q; acc_d = acc_q; ash_d = ash_q; b_d = b_q; cnt_d = cnt_q;
    bneg_d = bneg_q; negq_d = negq_q; negr_d = negr_q;
    if (start) begin
      op_d  = op;
      cnt_d = '1;
      if (is_div) begin
        negq_d = a_neg ^ b_neg;
        negr_d = a_neg;
        b_d    = b_mag;
        acc_d  = {{XLEN{1'b0}}, a_mag};
        if (div0) begin
          acc_d = {a, {XLEN{1'b1}}};
          negq_d = 1'b0; negr_d = 1'b0;
        end else if (ovf) begin
          acc_d = {{XLEN{1'b0}}, a};
          negq_d = 1'b0; negr_d = 1'b0;
        end
      end else begin
        acc_d  = '0;
        ash_d  = {{XLEN{a_neg}}, a};
        b_d    = b;
        bneg_d = (op == MD_MULH);
      end
    end else if (run) begin
      cnt_d = cnt_q - 1'b1;
      if (op_q[2]) begin
        acc_d = {diff[XLEN] ? hi[XLEN-1:0] : diff[XLEN-1:0], acc_q[XLEN-2:0], !diff[XLEN]};
      end else begin
        // A signed multiplier's top bit carries negative weight.
        acc_d = (last && bneg_q) ? acc_q - addend : acc_q + addend;
        ash_d = ash_q << 1;
        b_d   = b_q >> 1;
      end
    end

    if (op_q[2]) result = op_q[1] ? (negr_q ? -rem : rem) : (negq_q ? -quo : quo);
    else         result = (op_q == MD_MUL) ? quo : rem;
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      op_q <= '0; acc_q <= '0; ash_q <= '0; b_q <= '0; cnt_q <= '0;
      bneg_q <= 1'b0; negq_q <= 1'b0; negr_q <= 1'b0;
    end else begin
      op_q <= op_d; acc_q <= acc_d; ash_q <= ash_d; b_q <= b_d; cnt_q <= cnt_d;
      bneg_q <= bneg_d; negq_q <= negq_d; negr_q <= negr_d;
    end
  end
endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: inline ALU, operand-B mux, branch adder, iterative mul/div and
// a valid/ready EX/MEM output register.
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit MD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      wb_ctl,
  input  logic [2:0]      m_ctl,
  input  logic            alusrc,
  input  logic [3:0]      alu_op,
  input  logic            is_md,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] npc,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      wb_ctl_out,
  output logic            branch,
  output logic            memread,
  output logic            memwrite,
  output logic [XLEN-1:0] branch_target,
  output logic            zero,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] rdata2_out,
  output logic [4:0]      rd_out,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);

  state_e          state_q, state_d;
  exmem_ctl_t      ctl_q, ctl_d, cap_ctl_q, cap_ctl_d, in_ctl;
  logic            out_valid_q, out_valid_d, zero_q, zero_d;
  logic [XLEN-1:0] res_q, res_d, bt_q, bt_d, rd2_q, rd2_d;
  logic [XLEN-1:0] cap_rd2_q, cap_rd2_d, cap_npc_q, cap_npc_d, cap_imm_q, cap_imm_d;
  logic [XLEN-1:0] op_b, alu_res, md_res;
  logic            md_in, accept, md_special, md_last;

  assign in_ctl   = '{wb_ctl: wb_ctl, branch: m_ctl[2], memread: m_ctl[1],
                      memwrite: m_ctl[0], rd: rd};
  assign md_in    = MD_EN && is_md;
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush && !reset;
  assign accept   = in_valid && in_ready;
  assign op_b     = alusrc ? imm : rdata2;

  generate
    if (MD_EN) begin : g_md
      muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk(clk), .kill(reset || flush), .start(accept && md_in),
        .run(state_q == RUN), .op(md_op), .a(rdata1), .b(op_b),
        .special(md_special), .last(md_last), .result(md_res)
      );
    end else begin : g_no_md
      assign md_special = 1'b0;
      assign md_last    = 1'b0;
      assign md_res     = '0;
    end
  endgenerate

  always_comb begin
    unique case (alu_op)
      ALU_ADD:  alu_res = rdata1 + op_b;
      ALU_SUB:  alu_res = rdata1 - op_b;
      ALU_AND:  alu_res = rdata1 & op_b;
      ALU_OR:   alu_res = rdata1 | op_b;
      ALU_XOR:  alu_res = rdata1 ^ op_b;
      ALU_SLL:  alu_res = rdata1 << op_b[SW-1:0];
      ALU_SRL:  alu_res = rdata1 >> op_b[SW-1:0];
      ALU_SRA:  alu_res = $signed(rdata1) >>> op_b[SW-1:0];
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rdata1) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, rdata1 < op_b};
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    ctl_d = ctl_q; res_d = res_q; bt_d = bt_q; rd2_d = rd2_q; zero_d = zero_q;
    cap_ctl_d = cap_ctl_q; cap_rd2_d = cap_rd2_q; cap_npc_d = cap_npc_q; cap_imm_d = cap_imm_q;
    unique case (state_q)
      IDLE: if (accept) begin
        if (md_in) begin
          cap_ctl_d = in_ctl; cap_rd2_d = rdata2; cap_npc_d = npc; cap_imm_d = imm;
          state_d   = md_special ? DONE : RUN;
        end else begin
          out_valid_d = 1'b1;
          ctl_d = in_ctl; res_d = alu_res; rd2_d = rdata2;
          bt_d  = npc + imm; zero_d = (alu_res == '0);
        end
      end
      RUN: if (md_last) state_d = DONE;
      DONE: if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        ctl_d = cap_ctl_q; res_d = md_res; rd2_d = cap_rd2_q;
        bt_d  = cap_npc_q + cap_imm_q; zero_d = (md_res == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q <= IDLE; out_valid_q <= 1'b0;
      ctl_q <= '0; res_q <= '0; bt_q <= '0; rd2_q <= '0; zero_q <= 1'b0;
      cap_ctl_q <= '0; cap_rd2_q <= '0; cap_npc_q <= '0; cap_imm_q <= '0;
    end else begin
      state_q <= state_d; out_valid_q <= out_valid_d;
      ctl_q <= ctl_d; res_q <= res_d; bt_q <= bt_d; rd2_q <= rd2_d; zero_q <= zero_d;
      cap_ctl_q <= cap_ctl_d; cap_rd2_q <= cap_rd2_d;
      cap_npc_q <= cap_npc_d; cap_imm_q <= cap_imm_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign wb_ctl_out    = ctl_q.wb_ctl;
  assign branch        = ctl_q.branch;
  assign memread       = ctl_q.memread;
  assign memwrite      = ctl_q.memwrite;
  assign rd_out        = ctl_q.rd;
  assign alu_result    = res_q;
  assign rdata2_out    = rd2_q;
  assign branch_target = bt_q;
  assign zero          = zero_q;
  assign busy          = (state_q == RUN);
endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage with a valid/ready-handshaked EX/MEM output register and an iterative multiply/divide unit (RV32M/RV64M semantics). Sits between the ID/EX register and the MEM stage. Single-cycle ALU ops pass through in one cycle. MUL/DIV ops hold the stage for XLEN iterations and back-pressure ID/EX through `in_ready`. Branch target adder, ALU-source mux and EX/MEM pipeline register are folded into the block.

## Interface
- `XLEN`, default 32: datapath width; legal values 32 or 64.
- `MD_EN`, default 1: 1 instantiates the mul/div unit; 0 ties `is_md` off, so every op is treated as an ALU op.
- `clk` in 1: rising-edge clock; the block's only clock.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: kills any in-flight op and clears the output register; priority over all else.
- `in_valid` in 1: ID/EX presents an op.
- `in_ready` out 1: stage accepts an op this cycle.
- `wb_ctl` in 2 / `m_ctl` in 3 ({branch, memread, memwrite}): control, carried to output.
- `alusrc` in 1: 1 selects `imm` as operand B, 0 selects `rdata2`.
- `alu_op` in 4: decoded ALU op (package enum: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU).
- `is_md` in 1 / `md_op` in 3: M-extension op (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- `npc`, `rdata1`, `rdata2`, `imm` in XLEN each; `rd` in 5.
- `out_valid` out 1 / `out_ready` in 1: EX/MEM handshake.
- `wb_ctl_out` out 2; `branch`, `memread`, `memwrite` out 1 each.
- `branch_target` out XLEN: `npc + imm`, modulo 2^XLEN.
- `zero` out 1: `alu_result == 0`.
- `alu_result` out XLEN; `rdata2_out` out XLEN; `rd_out` out 5.
- `busy` out 1: mul/div iterating.

## Operation
- An op is accepted when `in_valid && in_ready`.
- `in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush`.
- States:
  - IDLE: ALU op is loaded into the output register at the accept edge. An MD op latches its operands and goes to RUN, or to DONE if special-cased.
  - RUN: one radix-2 iteration per cycle, using a counter from XLEN-1 down to 0. When the counter reaches 0, go to DONE.
  - DONE: when `!out_valid || out_ready`, load the output register and return to IDLE; otherwise wait in DONE.
- Multiply is shift-add on XLEN+1-bit sign-extended operands according to signedness.
  - MUL returns the low half of the product.
  - MULH, MULHSU and MULHU return the high half.
- Divide is restoring division on magnitudes, then sign fixup. The remainder takes the dividend's sign.
- Divide special cases bypass RUN:
  - Divisor 0: quotient = all ones, remainder = dividend.
  - Signed MIN / -1: quotient = MIN, remainder = 0.
- Control, `rd`, `rdata2`, `npc` and `imm` are captured at accept and presented with the result. `branch_target` and `zero` are computed from the captured values.
- Output register holds while `out_valid && !out_ready`. It clears `out_valid` when `out_ready` is high and no new result loads.
- `flush`: state goes to IDLE, `out_valid` goes to 0, the counter resets and the captured op is dropped.
- `reset`: same effect as `flush`. Every output register goes to 0. `in_ready` is combinational and equals 0 during reset, 1 after.

## Timing
- ALU op accepted at edge t: `out_valid` is 1 after edge t, i.e. 1-cycle latency. Back-to-back issue is allowed every cycle while `out_ready` = 1.
- MD op accepted at edge t: iterations run on edges t+1 … t+XLEN, and the result loads at edge t+XLEN+1. `in_ready` = 0 and `busy` = 1 from t to t+XLEN.
- Special-case divide: result loads at edge t+1.
- `out_ready` low during DONE adds one cycle per stalled cycle. No result is lost or duplicated.
- `flush` and `in_valid` in the same cycle: no accept, and the output is cleared.

## Structure
- Package `ex_pkg`: `alu_op_e`, `md_op_e`, EX/MEM payload struct, and state enum {IDLE, RUN, DONE}.
- Sub-module `muldiv_iter`: operand latch, counter, shift-add / restoring-divide datapath and special-case detect. It has a start/done interface and is absent when MD_EN = 0.
- ALU and operand-B mux are kept inline.

## Test plan
- ALU stream: ADD with 5 and 7, then SUB with 7 and 7, issued back-to-back, `out_ready` = 1. Results are 12 with `zero` = 0, then 0 with `zero` = 1, on consecutive cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF (XLEN = 32). Result 0xFFFFFFFE appears 33 cycles after accept. `in_ready` stays 0 throughout.
- DIV -7 / 2 gives -3; REM -7 / 2 gives -1. DIVU 10 / 0 gives 0xFFFFFFFF with 1-cycle latency. DIV 0x80000000 / -1 gives 0x80000000.
- Back-pressure: hold `out_ready` = 0 for 5 cycles with a result pending. Output payload and `out_valid` stay stable. Next op is accepted only in the cycle `out_ready` rises.
- `flush` asserted mid-RUN (iteration 10 of a DIV). `out_valid` stays 0, `in_ready` = 1 next cycle, and the next ADD completes correctly.
- Branch: `npc` = 0x100, `imm` = 0xFFFFFFF0, with `m_ctl` branch bit set. `branch_target` = 0xF0 and `branch` = 1. `reset` mid-MD clears all outputs to 0.
